// File: rtl/adder4b_display_ctrl_if.sv
// Operand strobe/nibble in, seven-segment display and phase out.
interface adder4b_display_ctrl_if;
   logic       load;
   logic [3:0] data;
   logic [6:0] segments;
   logic       dp;
   logic [2:0] phase;

   modport master (output load, data, input segments, dp, phase);
   modport slave  (input load, data, output segments, dp, phase);
endinterface

// File: rtl/adder4b_display_ctrl.sv
// Two-operand 4-bit adder: load A then B, then cycle the display through
// sum, A and B, each shown for PRESCALE clocks.
module adder4b_display_ctrl #(
   parameter int unsigned PRESCALE = 10_000_000
) (
   input logic                   clk,
   input logic                   rst,
   adder4b_display_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      EMPTY    = 3'd0,
      HAVE_A   = 3'd1,
      SHOW_A   = 3'd2,
      SHOW_B   = 3'd3,
      SHOW_SUM = 3'd4
   } state_t;

   localparam logic [23:0] LAST = 24'(PRESCALE - 1);

   state_t      state;
   logic [3:0]  a, b;
   logic [4:0]  sum;
   logic [23:0] cnt;
   logic        load_q;
   logic        load_edge;
   logic [4:0]  sum_new;

   assign load_edge = bus.load & ~load_q;
   assign sum_new   = {1'b0, a} + {1'b0, bus.data};

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      // load_q follows load even in reset, so a load held high across
      // reset release is not seen as a fresh edge.
      load_q <= bus.load;
      if (rst) begin
         state        <= EMPTY;
         a            <= 4'd0;
         b            <= 4'd0;
         sum          <= 5'd0;
         cnt          <= 24'd0;
         bus.segments <= 7'h00;
         bus.dp       <= 1'b0;
         bus.phase    <= EMPTY;
      end else begin
         case (state)
            EMPTY, SHOW_A, SHOW_B, SHOW_SUM: begin
               if (load_edge) begin
                  a            <= bus.data;
                  state        <= HAVE_A;
                  cnt          <= 24'd0;
                  bus.segments <= hex7(bus.data);
                  bus.dp       <= 1'b0;
                  bus.phase    <= HAVE_A;
               end else if (state != EMPTY) begin
                  if (cnt == LAST) begin
                     cnt <= 24'd0;
                     case (state)
                        SHOW_SUM: begin
                           state        <= SHOW_A;
                           bus.segments <= hex7(a);
                           bus.dp       <= 1'b0;
                           bus.phase    <= SHOW_A;
                        end
                        SHOW_A: begin
                           state        <= SHOW_B;
                           bus.segments <= hex7(b);
                           bus.dp       <= 1'b0;
                           bus.phase    <= SHOW_B;
                        end
                        default: begin
                           state        <= SHOW_SUM;
                           bus.segments <= hex7(sum[3:0]);
                           bus.dp       <= sum[4];
                           bus.phase    <= SHOW_SUM;
                        end
                     endcase
                  end else begin
                     cnt <= cnt + 24'd1;
                  end
               end
            end
            HAVE_A: begin
               if (load_edge) begin
                  b            <= bus.data;
                  sum          <= sum_new;
                  state        <= SHOW_SUM;
                  cnt          <= 24'd0;
                  bus.segments <= hex7(sum_new[3:0]);
                  bus.dp       <= sum_new[4];
                  bus.phase    <= SHOW_SUM;
               end
            end
            default: begin
               state        <= EMPTY;
               cnt          <= 24'd0;
               bus.segments <= 7'h00;
               bus.dp       <= 1'b0;
               bus.phase    <= EMPTY;
            end
         endcase
      end
   end
endmodule
